// File: rtl/sap_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sap_controller_sequencer
// Purpose  : SAP-1 controller-sequencer. A 6-state one-hot ring counter
//            (T1..T6) steps the fetch/execute cycle. The 12-bit control word
//            is decoded combinationally from the ring state and the opcode.
//            A sticky halt latch freezes the machine on HLT.
// Ports    : clk      - system clock, rising edge active
//            clear_n  - asynchronous active-low reset
//            run      - 1 = advance, 0 = hold state and force con to zero
//            opcode   - instruction register upper nibble (valid from T4)
//            t_state  - one-hot ring state, bit0 = T1 ... bit5 = T6
//            con      - control word {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
//            halt     - set after HLT is decoded, cleared only by clear_n
// Revision : 1.0 - initial release
// ============================================================================
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [5:0]  t_state,
  output logic [11:0] con,
  output logic        halt
);

  // Ring states (one-hot)
  localparam logic [5:0] C_T1 = 6'b000001;
  localparam logic [5:0] C_T2 = 6'b000010;
  localparam logic [5:0] C_T3 = 6'b000100;
  localparam logic [5:0] C_T4 = 6'b001000;
  localparam logic [5:0] C_T5 = 6'b010000;
  localparam logic [5:0] C_T6 = 6'b100000;

  // Control word bit masks
  localparam logic [11:0] C_CP = 12'h800;
  localparam logic [11:0] C_EP = 12'h400;
  localparam logic [11:0] C_LM = 12'h200;
  localparam logic [11:0] C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080;
  localparam logic [11:0] C_EI = 12'h040;
  localparam logic [11:0] C_LA = 12'h020;
  localparam logic [11:0] C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EU = 12'h004;
  localparam logic [11:0] C_LB = 12'h002;
  localparam logic [11:0] C_LO = 12'h001;

  logic [5:0] t_state_q, t_state_d;
  logic       halt_q, halt_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      t_state_q <= C_T1;
      halt_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halt_q    <= halt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    t_state_d = t_state_q;
    halt_d    = halt_q;
    if (run && !halt_q) begin
      case (t_state_q)
        C_T1: t_state_d = C_T2;
        C_T2: t_state_d = C_T3;
        C_T3: t_state_d = C_T4;
        C_T4: begin
          // HLT parks the ring in T4; halt then blocks all further advance.
          if (opcode == OP_HLT) begin
            halt_d = 1'b1;
          end else begin
            t_state_d = C_T5;
          end
        end
        C_T5: t_state_d = C_T6;
        C_T6: t_state_d = C_T1;
        // Any non-one-hot pattern recovers to the start of a fetch.
        default: t_state_d = C_T1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: control word from registered state and opcode
  // --------------------------------------------------------------------------
  always_comb begin
    con = 12'h000;
    if (run && !halt_q) begin
      case (t_state_q)
        C_T1: con = C_EP | C_LM;
        C_T2: con = C_CP;
        C_T3: con = C_CE | C_LI;
        C_T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            con = C_EI | C_LM;
          end else if (opcode == OP_OUT) begin
            con = C_EA | C_LO;
          end
        end
        C_T5: begin
          if (opcode == OP_LDA) begin
            con = C_CE | C_LA;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            con = C_CE | C_LB;
          end
        end
        C_T6: begin
          if (opcode == OP_ADD) begin
            con = C_EU | C_LA;
          end else if (opcode == OP_SUB) begin
            con = C_SU | C_EU | C_LA;
          end
        end
        default: con = 12'h000;
      endcase
    end
  end

  assign t_state = t_state_q;
  assign halt    = halt_q;

endmodule
`default_nettype wire
